// File: rtl/serial_lsb_comparator_if.sv
// rtl/serial_lsb_comparator_if.sv - request/result bundle for the bit-serial comparator
interface serial_lsb_comparator_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_cmp;
  logic             busy;
  logic             done;
  logic             this_less;
  logic             this_greater;
  logic             this_eq;

  modport master (
    output start, a, b, signed_cmp,
    input  busy, done, this_less, this_greater, this_eq
  );

  modport slave (
    input  start, a, b, signed_cmp,
    output busy, done, this_less, this_greater, this_eq
  );
endinterface

// File: rtl/serial_lsb_comparator.sv
// rtl/serial_lsb_comparator.sv - LSB-first bit-serial unsigned/signed magnitude comparator
module serial_lsb_comparator #(
  parameter int WIDTH = 8
) (
  input logic                   clk,
  input logic                   reset,
  serial_lsb_comparator_if.slave cmp
);
  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {F_EQ, F_LT, F_GT} flag_t;

  state_t           state;
  flag_t            flag;
  flag_t            flag_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             sgn;
  logic [IW-1:0]    idx;
  logic             last_bit;

  assign last_bit = (idx == IW'(WIDTH - 1));

  // A higher differing bit always overrides; only the sign bit flips meaning.
  always_comb begin
    flag_next = flag;
    if (a_sh[0] != b_sh[0]) begin
      if (last_bit && sgn) flag_next = a_sh[0] ? F_LT : F_GT;
      else                 flag_next = a_sh[0] ? F_GT : F_LT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      flag             <= F_EQ;
      a_sh             <= '0;
      b_sh             <= '0;
      sgn              <= 1'b0;
      idx              <= '0;
      cmp.busy         <= 1'b0;
      cmp.done         <= 1'b0;
      cmp.this_less    <= 1'b0;
      cmp.this_greater <= 1'b0;
      cmp.this_eq      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          cmp.done <= 1'b0;
          if (cmp.start) begin
            a_sh     <= cmp.a;
            b_sh     <= cmp.b;
            sgn      <= cmp.signed_cmp;
            idx      <= '0;
            flag     <= F_EQ;
            cmp.busy <= 1'b1;
            state    <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          flag <= flag_next;
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          idx  <= idx + 1'b1;
          if (last_bit) begin
            state            <= DONE;
            cmp.busy         <= 1'b0;
            cmp.done         <= 1'b1;
            cmp.this_less    <= (flag_next == F_LT);
            cmp.this_greater <= (flag_next == F_GT);
            cmp.this_eq      <= (flag_next == F_EQ);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_lsb_comparator.sv
// tb/tb_serial_lsb_comparator.sv - self-checking bench for serial_lsb_comparator
module tb_serial_lsb_comparator;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  serial_lsb_comparator_if #(.WIDTH(W)) bus ();

  serial_lsb_comparator #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .cmp   (bus)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sgn;
    logic [2:0]   exp_res;  // {less, greater, eq}
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [2:0] ref_cmp(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    int xi, yi;
    if (s) begin
      xi = $signed(x);
      yi = $signed(y);
    end else begin
      xi = int'(x);
      yi = int'(y);
    end
    return {xi < yi, xi > yi, xi == yi};
  endfunction

  function automatic logic [2:0] res();
    return {bus.this_less, bus.this_greater, bus.this_eq};
  endfunction

  // Starts a compare, scrambles the bus after acceptance, returns edges until done.
  task automatic do_cmp(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts, output int lat);
    bus.start = 1'b1;
    bus.a = ta;
    bus.b = tb_v;
    bus.signed_cmp = ts;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a = W'($urandom);
    bus.b = W'($urandom);
    bus.signed_cmp = 1'($urandom);
    check("busy_after_accept", 32'(bus.busy), 1);
    lat = 0;
    while (!bus.done && lat < W + 4) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat, n_done, first, gap;
    logic [W-1:0] ra, rb;
    logic rs;
    logic [2:0] held;

    tbl[0] = '{8'h5A, 8'h5B, 1'b0, 3'b100};
    tbl[1] = '{8'h80, 8'h7F, 1'b0, 3'b010};
    tbl[2] = '{8'h80, 8'h7F, 1'b1, 3'b100};
    tbl[3] = '{8'hFF, 8'hFF, 1'b1, 3'b001};
    tbl[4] = '{8'h01, 8'h80, 1'b0, 3'b100};
    tbl[5] = '{8'h00, 8'h00, 1'b0, 3'b001};
    tbl[6] = '{8'h7F, 8'h80, 1'b1, 3'b010};
    tbl[7] = '{8'hFE, 8'hFF, 1'b1, 3'b100};

    reset = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.signed_cmp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_busy", 32'(bus.busy), 0);
    check("reset_done", 32'(bus.done), 0);
    check("reset_result", 32'(res()), 0);

    foreach (tbl[i]) begin
      do_cmp(tbl[i].a, tbl[i].b, tbl[i].sgn, lat);
      check($sformatf("tbl%0d_latency", i), 32'(lat), W);
      check($sformatf("tbl%0d_busy_at_done", i), 32'(bus.busy), 0);
      check($sformatf("tbl%0d_result", i), 32'(res()), 32'(tbl[i].exp_res));
      held = res();
      @(posedge clk); #1;
      check($sformatf("tbl%0d_done_pulse", i), 32'(bus.done), 0);
      check($sformatf("tbl%0d_hold", i), 32'(res()), 32'(held));
    end

    // start pulsed mid-run must be ignored
    bus.start = 1'b1;
    bus.a = 8'h10;
    bus.b = 8'h20;
    bus.signed_cmp = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    bus.start = 1'b1;
    bus.a = 8'hFF;
    bus.b = 8'h00;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a = W'($urandom);
    bus.b = W'($urandom);
    n_done = 0;
    first = -1;
    for (int e = 4; e <= 12; e++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        n_done++;
        if (first < 0) first = e;
        check("ignore_result", 32'(res()), 32'(3'b100));
      end
    end
    check("ignore_done_count", 32'(n_done), 1);
    check("ignore_done_edge", 32'(first), 8);

    // back-to-back: start held through DONE
    do_cmp(8'h10, 8'h20, 1'b0, lat);
    check("b2b_first_latency", 32'(lat), W);
    bus.start = 1'b1;
    bus.a = 8'h03;
    bus.b = 8'h02;
    bus.signed_cmp = 1'b0;
    gap = 0;
    do begin
      @(posedge clk); #1;
      gap++;
      if (gap == 1) begin
        bus.start = 1'b0;
        check("b2b_busy", 32'(bus.busy), 1);
      end
    end while (!bus.done && gap < 20);
    check("b2b_gap", 32'(gap), W + 1);
    check("b2b_result", 32'(res()), 32'(3'b010));

    // reset in the middle of a run
    bus.start = 1'b1;
    bus.a = 8'h33;
    bus.b = 8'h44;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midreset_busy", 32'(bus.busy), 0);
    check("midreset_done", 32'(bus.done), 0);
    check("midreset_result", 32'(res()), 0);
    n_done = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.done) n_done++;
    end
    check("midreset_no_done", 32'(n_done), 0);
    do_cmp(8'h81, 8'h01, 1'b1, lat);
    check("after_reset_latency", 32'(lat), W);
    check("after_reset_result", 32'(res()), 32'(3'b100));
    @(posedge clk); #1;

    // reset beats a simultaneous start
    reset = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.start = 1'b0;
    check("reset_wins_busy", 32'(bus.busy), 0);
    check("reset_wins_result", 32'(res()), 0);
    @(posedge clk); #1;
    check("reset_wins_idle", 32'(bus.busy), 0);

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = (i % 5 == 0) ? ra : W'($urandom);
      rs = 1'($urandom);
      do_cmp(ra, rb, rs, lat);
      check($sformatf("rand%0d_latency", i), 32'(lat), W);
      check($sformatf("rand%0d_result a=%h b=%h s=%0d", i, ra, rb, rs), 32'(res()), 32'(ref_cmp(ra, rb, rs)));
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
